fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  32  word-aligned read address.
REQ-006 SHALL have port: imem_ack  input  1  one-cycle read-completion pulse.
REQ-007 SHALL have port: imem_rdata  input  32  read data, valid only in the imem_ack cycle.
REQ-008 SHALL have port: instr  output  32  fetched instruction word to the decoder; opcode in instr[31:26].
REQ-009 SHALL have port: instr_valid  output  1  instr and pc_out valid.
REQ-010 SHALL have port: instr_ready  input  1  decoder accepts instr.
REQ-011 SHALL have port: pc_out  output  32  address of instr.
REQ-012 SHALL have port: pc_plus4  output  32  pc_out+4; JAL link value.
REQ-013 SHALL have port: redirect  input  1  branch/jump taken pulse.
REQ-014 SHALL have port: redirect_target  input  32  new fetch address.
REQ-015 SHALL have port: fetch_fault  output  1  memory timeout; present only with FETCH_TIMEOUT_EN.

Function
REQ-016 SHALL implement FSM states BOOT, REQ, FLUSH, VALID, plus FAULT with FETCH_TIMEOUT_EN.
REQ-017 SHALL leave BOOT for REQ on the first cycle with rst_n high.
REQ-018 SHALL assert imem_req in REQ and FLUSH only, with imem_addr stable until imem_ack.
REQ-019 SHALL, in REQ with imem_ack and no redirect, register imem_rdata into instr and enter VALID; instr_valid rises in the next cycle, giving 1-cycle latency after ack.
REQ-020 SHALL, in VALID, hold instr, pc_out and instr_valid stable until instr_ready; on instr_ready, pc <= pc+4 and enter REQ.
REQ-021 SHALL give redirect priority over every other event in all states except BOOT and FAULT.
REQ-022 SHALL, on redirect in VALID, drop instr and clear instr_valid the next cycle; pc <= target; enter REQ, even with simultaneous instr_ready.
REQ-023 SHALL, on redirect in REQ with imem_ack in the same cycle, discard rdata; pc <= target; enter REQ.
REQ-024 SHALL, on redirect in REQ without imem_ack, enter FLUSH and hold the old address until ack; discard that data; then enter REQ at the target.
REQ-025 SHALL, on redirect in FLUSH, replace the pending target so the latest redirect wins.
REQ-026 SHALL force redirect_target[1:0] to 2'b00.
REQ-027 SHALL wrap pc+4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-028 SHALL ignore imem_ack outside REQ and FLUSH.

Reset
REQ-029 SHALL, while rst_n is low at a clock edge, set state BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, timeout counter=0.
REQ-030 SHALL abandon any in-flight request on reset; a stale imem_ack in BOOT is ignored.

Configuration
REQ-031 SHALL, with macro FETCH_TIMEOUT_EN defined, count consecutive REQ/FLUSH cycles without imem_ack; after 16 such cycles, enter FAULT.
REQ-032 SHALL, in FAULT, drive imem_req=0 and instr_valid=0, hold fetch_fault=1, and leave only via reset.
REQ-033 SHALL clear the counter on every imem_ack and on every state entry.
REQ-034 SHALL, without FETCH_TIMEOUT_EN, omit the counter, FAULT and fetch_fault port, and wait indefinitely for imem_ack.

Structure
REQ-035 SHALL take state encoding, default RESET_PC and TIMEOUT_CYCLES=16 from shared package fetch_pkg.
REQ-036 SHALL instantiate sub-module pc_inc (32-bit +4 adder) for both pc advance and pc_plus4.

Verification
REQ-037 SHALL cover: reset release, ack 2 cycles after req with rdata 32'h8C01_0004 -> imem_addr=0, instr=32'h8C01_0004, pc_out=0, pc_plus4=4, then next req at 4.
REQ-038 SHALL cover: instr_ready low 5 cycles in VALID -> instr, pc_out stable, no imem_req; ready high -> next imem_addr=pc+4.
REQ-039 SHALL cover: redirect to 32'h0000_0103 in REQ without ack, ack 3 cycles later -> data discarded, next imem_addr=32'h0000_0100, instr_valid never set for discarded word.
REQ-040 SHALL cover: redirect and instr_ready same cycle in VALID -> instr_valid low next cycle, next fetch at target.
REQ-041 SHALL cover: pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-042 SHALL cover, with FETCH_TIMEOUT_EN: no ack for 16 cycles -> fetch_fault=1, imem_req=0 until reset, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset address and the memory-timeout limit.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYCLES   = 16;
    localparam int unsigned TMO_CNT_W        = $clog2(TIMEOUT_CYCLES);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/pc_inc.sv
// 32-bit program-counter incrementer; wraps modulo 2^32.
module pc_inc (
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_plus4
);

    assign o_pc_plus4 = i_pc + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with redirect handling.
// Optional memory-timeout fault logic is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
`ifdef FETCH_TIMEOUT_EN
    output logic        fetch_fault,
`endif
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_target;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_imem_req;
    logic [31:0]  w_pc_next4;
    logic [31:0]  w_redirect_pc;

    assign w_redirect_pc = word_align(redirect_target);

    pc_inc u_pc_inc (
        .i_pc       (r_pc),
        .o_pc_plus4 (w_pc_next4)
    );

    // r_pc doubles as the request address: in FLUSH it still holds the
    // abandoned address while the new target waits in r_target.
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc;
    assign pc_plus4    = w_pc_next4;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic                 r_fault;
    logic                 w_tmo_expired;
    logic                 w_tmo_wait;
    logic                 w_tmo_hit;

    // A cycle counts toward the timeout only if the FSM stays put waiting.
    assign w_tmo_wait    = ((r_state == ST_REQ) && !redirect) || (r_state == ST_FLUSH);
    assign w_tmo_expired = (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_tmo_hit     = w_tmo_wait && !imem_ack && w_tmo_expired;
    assign fetch_fault   = r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            if (w_tmo_wait && !imem_ack && !w_tmo_expired) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo_hit) begin
                r_fault <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_target      <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_REQ;
                    r_imem_req <= 1'b1;
                end
                ST_REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_pc <= w_redirect_pc;
                        end else begin
                            r_target <= w_redirect_pc;
                            r_state  <= ST_FLUSH;
                        end
                    end else if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_VALID;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ST_FAULT;
                    end
`endif
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        r_target <= w_redirect_pc;
                    end
                    if (imem_ack) begin
                        r_pc    <= redirect ? w_redirect_pc : r_target;
                        r_state <= ST_REQ;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ST_FAULT;
                    end
`endif
                end
                ST_VALID: begin
                    if (redirect) begin
                        r_instr       <= '0;
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_redirect_pc;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_REQ;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_pc_next4;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_REQ;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ST_FAULT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state       <= ST_BOOT;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized traffic
// checked against an architectural program-counter model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
`ifdef FETCH_TIMEOUT_EN
        .fetch_fault     (fetch_fault),
`endif
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Contents of the simulated instruction memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Drive one cycle of inputs, then move to just after the next rising edge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic ready,
                        input logic redir, input logic [31:0] tgt);
        imem_ack        = ack;
        imem_rdata      = rdata;
        instr_ready     = ready;
        redirect        = redir;
        redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    logic        pending;
    logic [31:0] pend_addr;
    int unsigned delay;
    logic [31:0] model_pc;
    int          accepts;

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0;
        repeat (3) idle();

        // Reset state
        check_eq("rst_req",   32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc",    pc_out, RESET_PC);
`ifdef FETCH_TIMEOUT_EN
        check_eq("rst_fault", 32'(fetch_fault), 32'h0);
`endif

        // Release with a stale ack present: BOOT must ignore it
        rst_n = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check_eq("boot_valid", 32'(instr_valid), 32'h0);
        check_eq("boot_req",   32'(imem_req), 32'h1);
        check_eq("boot_addr",  imem_addr, RESET_PC);

        // First fetch, ack two cycles after the request
        idle();
        check_eq("wait_addr0", imem_addr, 32'h0);
        idle();
        check_eq("wait_addr1", imem_addr, 32'h0);
        step(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'h0);
        check_eq("f0_valid", 32'(instr_valid), 32'h1);
        check_eq("f0_instr", instr, 32'h8C01_0004);
        check_eq("f0_pc",    pc_out, 32'h0);
        check_eq("f0_pc4",   pc_plus4, 32'h4);
        check_eq("f0_req",   32'(imem_req), 32'h0);

        // Stall in VALID
        for (int i = 0; i < 5; i++) begin
            idle();
            check_eq("stall_instr", instr, 32'h8C01_0004);
            check_eq("stall_pc",    pc_out, 32'h0);
            check_eq("stall_valid", 32'(instr_valid), 32'h1);
            check_eq("stall_req",   32'(imem_req), 32'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("adv_req",   32'(imem_req), 32'h1);
        check_eq("adv_addr",  imem_addr, 32'h4);
        check_eq("adv_valid", 32'(instr_valid), 32'h0);

        // Redirect in REQ without ack: old address held, its data discarded
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        check_eq("fl_addr", imem_addr, 32'h4);
        check_eq("fl_req",  32'(imem_req), 32'h1);
        for (int i = 0; i < 2; i++) begin
            idle();
            check_eq("fl_hold",  imem_addr, 32'h4);
            check_eq("fl_valid", 32'(instr_valid), 32'h0);
        end
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        check_eq("fl_done_valid", 32'(instr_valid), 32'h0);
        check_eq("fl_done_addr",  imem_addr, 32'h0000_0100);
        check_eq("fl_done_req",   32'(imem_req), 32'h1);
        step(1'b1, mem_word(32'h100), 1'b0, 1'b0, 32'h0);
        check_eq("tgt_valid", 32'(instr_valid), 32'h1);
        check_eq("tgt_pc",    pc_out, 32'h0000_0100);
        check_eq("tgt_instr", instr, mem_word(32'h100));

        // Redirect and ready together in VALID
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
        check_eq("rr_valid", 32'(instr_valid), 32'h0);
        check_eq("rr_addr",  imem_addr, 32'h0000_0200);
        check_eq("rr_req",   32'(imem_req), 32'h1);

        // Redirect with simultaneous ack; unaligned target forced to word boundary
        step(1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check_eq("ra_valid", 32'(instr_valid), 32'h0);
        check_eq("ra_addr",  imem_addr, 32'hFFFF_FFFC);
        step(1'b1, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
        check_eq("wrap_pc",  pc_out, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc_plus4, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);
        check_eq("wrap_req",  32'(imem_req), 32'h1);

        // Randomized traffic against the architectural model
        pending  = 1'b0;
        pend_addr = '0;
        delay    = 0;
        model_pc = 32'h0;
        accepts  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        a;
            logic [31:0] d;
            logic        rdy;
            logic        rd;
            logic [31:0] tg;
            rdy = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 9) == 0);
            tg  = $urandom;
            a   = 1'b0;
            d   = $urandom;
            if (instr_valid) begin
                check_eq("rnd_pc",    pc_out, model_pc);
                check_eq("rnd_instr", instr, mem_word(model_pc));
                check_eq("rnd_pc4",   pc_plus4, model_pc + 32'd4);
                check_eq("rnd_noreq", 32'(imem_req), 32'h0);
            end
            if (imem_req) begin
                if (!pending) begin
                    pending   = 1'b1;
                    pend_addr = imem_addr;
                    delay     = $urandom_range(0, 3);
                end else begin
                    check_eq("rnd_addr_hold", imem_addr, pend_addr);
                end
                if (delay == 0) begin
                    a       = 1'b1;
                    d       = mem_word(pend_addr);
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                a = 1'b1;
            end
            if (rd) begin
                model_pc = tg & ~32'h3;
            end else if (instr_valid && rdy) begin
                model_pc = model_pc + 32'd4;
                accepts++;
            end
            step(a, d, rdy, rd, tg);
        end
        check_eq("rnd_progress", 32'(accepts > 100), 32'h1);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: fault after sixteen waiting cycles
        rst_n = 1'b0;
        repeat (2) idle();
        check_eq("to_rst_fault", 32'(fetch_fault), 32'h0);
        rst_n = 1'b1;
        idle();
        repeat (15) idle();
        check_eq("to_pre_fault", 32'(fetch_fault), 32'h0);
        check_eq("to_pre_req",   32'(imem_req), 32'h1);
        idle();
        check_eq("to_fault", 32'(fetch_fault), 32'h1);
        check_eq("to_req",   32'(imem_req), 32'h0);
        check_eq("to_valid", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h40);
            check_eq("to_sticky", 32'(fetch_fault), 32'h1);
            check_eq("to_noreq",  32'(imem_req), 32'h0);
        end
        rst_n = 1'b0;
        idle();
        check_eq("to_clear", 32'(fetch_fault), 32'h0);
        rst_n = 1'b1;
        idle();
        check_eq("to_restart_req",  32'(imem_req), 32'h1);
        check_eq("to_restart_addr", imem_addr, RESET_PC);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
